fb_capture_ctrl: RTL and testbench

//  Write-side sequencer for the camera framebuffer. It runs in the camera pixel-clock domain.
//  - Parses the camera YUV422 byte stream (VSYNC/HREF framed) and keeps only the luma (Y) bytes.
//  - Drives the framebuffer data, write-enable and linear write address (row*H_ACTIVE+col).
//  - Arms and frames captures (single-shot or continuous) and reports completion and errors.
//  The VGA read side and the dual-clock RAM are outside this block.

---
 rtl/fb_capture_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fb_capture_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_capture_ctrl.sv
// Camera write-side sequencer: keeps the Y bytes of a VSYNC/HREF framed YUV422 stream and
// writes them to the framebuffer. Define FB_DOUBLE_BUFFER_EN for two-bank ping-pong.
module fb_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 20,
  parameter int Y_PHASE  = 0
) (
  input  logic              CLOCK_24,
  input  logic              reset_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture,
  input  logic              continuous,
  output logic [7:0]        Y_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic              rd_bank
);
  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
  localparam logic              Y_PH      = 1'(Y_PHASE);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_FRAME, S_ACTIVE, S_END} state_t;
  state_t state_reg, state_next;

  logic              vsync_d_reg, href_d_reg, phase_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [ADDR_W-1:0] addr_reg, line_start_reg, base;
  logic [7:0]        y_in_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic              err_frame_reg, frame_err_reg;
  logic              vs_rise, vs_fall, href_fall, in_active, y_byte, col_ok, row_ok;
  logic              do_write, line_end, short_line, short_frame, err_clear, frame_start;

  assign vs_rise     = cam_vsync & ~vsync_d_reg;
  assign vs_fall     = ~cam_vsync & vsync_d_reg;
  assign href_fall   = ~cam_href & href_d_reg;
  assign in_active   = (state_reg == S_ACTIVE);
  assign y_byte      = in_active && cam_href && (phase_reg == Y_PH);
  assign col_ok      = (col_reg < COL_MAX);
  assign row_ok      = (row_reg < ROW_MAX);
  assign do_write    = y_byte && col_ok && row_ok;
  assign line_end    = in_active && href_fall;
  assign short_line  = line_end && (col_reg != '0) && col_ok;
  assign short_frame = in_active && vs_rise && row_ok;
  assign err_clear   = (state_reg == S_IDLE) && capture;

  assign busy       = (state_reg != S_IDLE);
  assign frame_done = (state_reg == S_END);
  assign Y_in       = y_in_reg;
  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign frame_err  = frame_err_reg;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(H_ACTIVE * V_ACTIVE);
  logic rd_bank_reg;

  // Only a frame that completed without error is handed to the reader.
  always_ff @(posedge CLOCK_24 or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank_reg <= 1'b0;
    end else if (state_reg == S_END && !err_frame_reg) begin
      rd_bank_reg <= ~rd_bank_reg;
    end
  end

  assign rd_bank = rd_bank_reg;
  assign base    = rd_bank_reg ? '0 : BANK1_BASE;
`else
  assign rd_bank = 1'b0;
  assign base    = '0;
`endif

  always_ff @(posedge CLOCK_24 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // SYNC waits for a vsync rise so capture always starts on a whole frame.
  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    case (state_reg)
      S_IDLE:   if (capture || continuous) state_next = S_SYNC;
      S_SYNC:   if (vs_rise) state_next = S_FRAME;
      S_FRAME: begin
        if (vs_fall) begin
          state_next  = S_ACTIVE;
          frame_start = 1'b1;
        end
      end
      S_ACTIVE: if (vs_rise) state_next = S_END;
      S_END:    state_next = continuous ? S_FRAME : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_24 or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d_reg    <= 1'b0;
      href_d_reg     <= 1'b0;
      phase_reg      <= 1'b0;
      col_reg        <= '0;
      row_reg        <= '0;
      addr_reg       <= '0;
      line_start_reg <= '0;
      y_in_reg       <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      err_frame_reg  <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      vsync_d_reg <= cam_vsync;
      href_d_reg  <= cam_href;
      phase_reg   <= cam_href ? ~phase_reg : 1'b0;
      wr_en_reg   <= do_write;
      if (do_write) begin
        y_in_reg    <= cam_data;
        wr_addr_reg <= addr_reg;
        addr_reg    <= addr_reg + 1'b1;
      end
      if (y_byte && col_ok) begin
        col_reg <= col_reg + 1'b1;
      end
      // Address jumps to the next line start, so dropped overrun pixels leave no gap.
      if (line_end) begin
        col_reg <= '0;
        if (row_ok) begin
          row_reg        <= row_reg + 1'b1;
          line_start_reg <= line_start_reg + LINE_STEP;
          addr_reg       <= line_start_reg + LINE_STEP;
        end
      end
      if (short_line || short_frame) begin
        err_frame_reg <= 1'b1;
        frame_err_reg <= 1'b1;
      end else if (err_clear) begin
        frame_err_reg <= 1'b0;
      end
      if (frame_start) begin
        row_reg        <= '0;
        col_reg        <= '0;
        phase_reg      <= 1'b0;
        addr_reg       <= base;
        line_start_reg <= base;
        err_frame_reg  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fb_capture_ctrl.sv
// Self-checking bench for fb_capture_ctrl on a scaled 8x6 frame: directed frames plus random
// frames, checked against a frame-level model of which Y bytes must land at which address.
`timescale 1ns/1ps
module tb_fb_capture_ctrl;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 8;
  localparam int HV = H * V;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cam_vsync = 1'b0, cam_href = 1'b0, capture = 1'b0, continuous = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic [7:0]    Y_in;
  logic          wr_en, busy, frame_done, frame_err, rd_bank;
  logic [AW-1:0] wr_addr;

  fb_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .Y_PHASE(0)) dut (
    .CLOCK_24(clk), .reset_n(reset_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .capture(capture), .continuous(continuous), .Y_in(Y_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .rd_bank(rd_bank)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t  exp_q[$];
  wr_t  e_cur;
  int   n_tests = 0, n_fail = 0;
  // model state
  bit   m_active = 0, m_armed = 0, m_busy = 0, m_err = 0, m_bank = 0, m_ferr = 0;
  int   m_base = 0, m_done = 0, m_lines = 0;
  // observed
  int   done_cnt = 0, wr_cnt = 0, first_addr = 0, last_addr = 0;
  int   last_wr_cnt = 0, last_first = 0, last_last = 0;
  logic [7:0] fb_img [0:255];
  int   sp_line = -1, sp_idx = 0, rst_line = -1, rst_byte = 0;
  logic [7:0] sp_val = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h, required no write", wr_addr, Y_in);
        end else begin
          e_cur = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e_cur.addr));
          check("Y_in", 32'(Y_in), 32'(e_cur.data));
        end
        if (wr_cnt == 0) first_addr = int'(wr_addr);
        last_addr = int'(wr_addr);
        wr_cnt++;
        fb_img[wr_addr] = Y_in;
      end
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_assert();
    #2 reset_n = 1'b0;
    exp_q.delete();
    m_active = 0; m_armed = 0; m_busy = 0; m_err = 0; m_bank = 0; m_ferr = 0;
    wr_cnt = 0;
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_Y_in", 32'(Y_in), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_rd_bank", 32'(rd_bank), 0);
  endtask

  task automatic pulse_capture();
    cyc();
    capture = 1'b1;
    if (!m_busy) begin
      m_armed = 1; m_busy = 1; m_err = 0;
    end
    cyc();
    capture = 1'b0;
  endtask

  task automatic set_cont(input bit v);
    cyc();
    continuous = v;
    if (v && !m_busy) begin
      m_armed = 1; m_busy = 1;
    end
  endtask

  // One HREF line; expected writes come from line/pixel indices of the Y bytes.
  task automatic send_line(input int l, input int len);
    int ny;
    if (m_active) m_lines++;
    for (int j = 0; j < len; j++) begin
      cyc();
      cam_href = 1'b1;
      cam_data = 8'($urandom);
      if (l == sp_line && j == sp_idx) cam_data = sp_val;
      if (l == sp_line && j == sp_idx + 1) cam_data = 8'h80;
      if (m_active && l < V && (j % 2) == 0 && (j / 2) < H)
        exp_q.push_back('{m_base + l * H + j / 2, int'(cam_data)});
      if (l == rst_line && j == rst_byte) reset_assert();
      if (l == rst_line && j == rst_byte + 3) #2 reset_n = 1'b1;
    end
    cyc();
    cam_href = 1'b0;
    cam_data = 8'h00;
    if (m_active) begin
      ny = (len + 1) / 2;
      if (ny > H) ny = H;
      if (ny > 0 && ny < H) m_ferr = 1;
    end
    repeat (2) cyc();
  endtask

  // Vertical blank: closes the running frame and opens the next one if armed.
  task automatic vblank(input string tag);
    cyc();
    cam_vsync = 1'b1;
    if (m_active) begin
      if (m_lines < V) m_ferr = 1;
      m_done++;
      if (m_ferr) m_err = 1;
      if (DB && !m_ferr) m_bank = ~m_bank;
      m_active = 0;
      if (continuous) m_armed = 1;
      else m_busy = 0;
    end
    repeat (3) cyc();
    check("frame_done_count", 32'(done_cnt), 32'(m_done));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("rd_bank", 32'(rd_bank), 32'(m_bank));
    check("busy", 32'(busy), 32'(m_busy));
    check("missing_writes", 32'(exp_q.size()), 0);
    $display("[TB] vblank %s: writes=%0d first=%0d last=%0d done=%0d err=%0b bank=%0b busy=%0b",
             tag, wr_cnt, first_addr, last_addr, done_cnt, frame_err, rd_bank, busy);
    last_wr_cnt = wr_cnt; last_first = first_addr; last_last = last_addr;
    wr_cnt = 0;
    if (m_armed) begin
      m_active = 1; m_armed = 0; m_ferr = 0; m_lines = 0;
      m_base = (DB && !m_bank) ? HV : 0;
    end
    cyc();
    cam_vsync = 1'b0;
    repeat (3) cyc();
  endtask

  function automatic int rand_len();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return 2 * H;
    if (r < 17) return 2 * H + int'($urandom_range(1, 5));
    return int'($urandom_range(1, 2 * H - 1));
  endfunction

  task automatic rand_frame();
    int n, r;
    n = ($urandom_range(0, 5) == 0) ? V - 1 : V + int'($urandom_range(0, 1));
    for (int l = 0; l < n; l++) begin
      send_line(l, rand_len());
      r = int'($urandom_range(0, 11));
      if (r == 0) pulse_capture();
      else if (r == 1) set_cont(~continuous);
    end
  endtask

  task automatic full_frame();
    for (int l = 0; l < V; l++) send_line(l, 2 * H);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("init_wr_en", 32'(wr_en), 0);
    check("init_busy", 32'(busy), 0);
    check("init_frame_done", 32'(frame_done), 0);
    check("init_frame_err", 32'(frame_err), 0);
    check("init_rd_bank", 32'(rd_bank), 0);
    check("init_wr_addr", 32'(wr_addr), 0);
    reset_n = 1'b1;
    repeat (2) cyc();

    // Frame A: full frame, marker byte pair at line 3, pixel 5
    pulse_capture();
    vblank("A-start");
    sp_line = 3; sp_idx = 10; sp_val = 8'h5A;
    full_frame();
    sp_line = -1;
    vblank("A-end");
    check("A_write_count", 32'(last_wr_cnt), 32'(HV));
    check("A_first_addr", 32'(last_first), DB ? 32'(HV) : 0);
    check("A_last_addr", 32'(last_last), DB ? 32'(2 * HV - 1) : 32'(HV - 1));
    check("A_marker", 32'(fb_img[(DB ? HV : 0) + 29]), 32'h5A);
    check("A_done", 32'(done_cnt), 1);
    check("A_busy", 32'(busy), 0);

    // Frame C: only 3 of 6 lines -> short frame
    pulse_capture();
    vblank("C-start");
    for (int l = 0; l < 3; l++) send_line(l, 2 * H);
    vblank("C-end");
    check("C_frame_err", 32'(frame_err), 1);
    check("C_done", 32'(done_cnt), 2);
    check("C_write_count", 32'(last_wr_cnt), 24);
    check("C_rd_bank_kept", 32'(rd_bank), DB ? 1 : 0);

    // Frame B: second line overruns by 4 bytes
    pulse_capture();
    vblank("B-start");
    for (int l = 0; l < V; l++) send_line(l, (l == 1) ? 2 * H + 4 : 2 * H);
    vblank("B-end");
    check("B_write_count", 32'(last_wr_cnt), 32'(HV));
    check("B_frame_err", 32'(frame_err), 0);
    check("B_line1_last", 32'(last_last), 32'(HV - 1));

    // Continuous over three frames, cleared during the third
    pulse_capture();
    set_cont(1'b1);
    vblank("K-start");
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < V; l++) begin
        send_line(l, 2 * H);
        if (k == 2 && l == 2) set_cont(1'b0);
      end
      vblank($sformatf("K%0d-end", k));
      check("K_first_addr", 32'(last_first), (DB && (k % 2 == 0)) ? 32'(HV) : 0);
      check("K_rd_bank", 32'(rd_bank), (DB && (k % 2 == 0)) ? 1 : 0);
    end
    check("K_done", 32'(done_cnt), 6);
    check("K_busy_end", 32'(busy), 0);

    // Random frames with random capture / continuous activity
    pulse_capture();
    for (int f = 0; f < 16; f++) begin
      vblank($sformatf("R%0d", f));
      rand_frame();
    end
    set_cont(1'b0);
    vblank("drain0");
    full_frame();
    vblank("drain1");
    vblank("drain2");

    // Reset in the middle of a captured frame, re-arm mid-frame
    pulse_capture();
    vblank("X-start");
    rst_line = 2; rst_byte = 5;
    for (int l = 0; l < V; l++) begin
      send_line(l, 2 * H);
      if (l == 2) pulse_capture();
    end
    rst_line = -1;
    vblank("X-rearm");
    check("X_no_writes_after_reset", 32'(last_wr_cnt), 0);
    full_frame();
    vblank("X-end");
    check("X_write_count", 32'(last_wr_cnt), 32'(HV));
    check("X_first_addr", 32'(last_first), DB ? 32'(HV) : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
